uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver. Captures each 1-cycle rx_valid
//  byte into a power-of-2 circular FIFO and presents the head byte to the CPU input path
//  through a valid/ready pop handshake. Reports fill level, a high-watermark flag
//  (RTS deassert hint) and a sticky overrun flag, so no host byte is lost silently.
// PARAMETERS
//  DEPTH    8   entries; power of 2, range 2..32
//  HIGH_WM  6   level at or above which hiwm_o asserts; range 1..DEPTH
// PORTS
//  clk_i        in   1      system clock; single clock domain
//  rst_i        in   1      reset; asynchronous, active-high
//  rx_data_i    in   8      byte from UART receiver
//  rx_valid_i   in   1      1-cycle push strobe from UART receiver
//  rd_data_o    out  8      head byte; valid only while rd_valid_o=1
//  rd_valid_o   out  1      FIFO non-empty
//  rd_ready_i   in   1      consumer pops head when rd_valid_o & rd_ready_i
//  level_o      out  AW+1   current occupancy 0..DEPTH; AW=$clog2(DEPTH)
//  full_o       out  1      level_o==DEPTH
//  hiwm_o       out  1      level_o>=HIGH_WM
//  overrun_o    out  1      sticky: a push was dropped
//  clr_i        in   1      sync flush: empties FIFO and clears overrun_o
// BEHAVIOUR
//  Reset (async assert, sync release): wr_ptr=rd_ptr=0, level=0 and overrun=0.
//   All outputs go low: rd_valid_o, full_o, hiwm_o, overrun_o=0, level_o=0, rd_data_o=8'h00.
//   Storage array is not reset. rd_data_o reads 0 while empty, so it is forced to 0.
//  Pointers: AW-bit wr_ptr/rd_ptr wrap modulo DEPTH; level is a separate AW+1-bit counter.
//  Push: rx_valid_i & (~full | pop). mem[wr_ptr]<=rx_data_i; wr_ptr+1.
//  Pop: rd_valid_o & rd_ready_i. rd_ptr+1.
//  Level update: +1 on push only, -1 on pop only, unchanged when both occur.
//  Show-ahead output: rd_data_o=mem[rd_ptr], combinational from array.
//   Push-to-rd_valid_o latency is 1 cycle (written byte visible the cycle after the strobe).
//  Empty + push + ready: no pop this cycle (rd_valid_o=0); byte is stored; level->1.
//  Full + push + pop same cycle: both accepted; level stays DEPTH; no overrun.
//  Full + push without pop: byte dropped; pointers unchanged; overrun_o<=1.
//   overrun_o holds until clr_i or reset.
//  clr_i has priority over push/pop in the same cycle.
//   Effect: ptrs=0, level=0, overrun_o=0; a coincident push is discarded and does not set overrun.
//  Flags are combinational from the registered level: full_o, hiwm_o, rd_valid_o=(level!=0).
//  Reset mid-stream: contents are abandoned. The next rx_valid_i after release is stored as
//   the first entry.
//  Illegal parameters (DEPTH not a power of 2, HIGH_WM>DEPTH) are rejected.
//   Mechanism: elaboration-time check under `ifndef SYNTHESIS; failure is $fatal.
// STRUCTURE
//  Single flat module. Contents: 2 pointer regs, level counter, overrun reg, DEPTH x 8 reg array.
//  No sub-module; memory is flops, which is small enough not to need a macro.
//  Shared constants go in tinybf_defs.vh (included by all UART blocks):
//   UART_DATA_W=8; default RX FIFO DEPTH/HIGH_WM.
//  Reset polarity localparam in the same file for the active-high domain.
// TESTING
//  1 Reset then push 8'hA5: rd_valid_o=1 next cycle; rd_data_o=A5; level_o=1.
//    Then pop with ready=1: rd_valid_o=0, level_o=0.
//  2 Push 0x01..0x08 (DEPTH=8), no pops: full_o=1 and hiwm_o from level 6.
//    Push 0x09: overrun_o=1, level_o=8. Drain returns 01..08 in order, no 09.
//  3 Full FIFO, push 0x55 with pop same cycle: pops 0x01; level stays 8; overrun_o stays 0.
//    0x55 emerges last.
//  4 Push 20 bytes interleaved with pops; pointer wraps twice.
//    Scoreboard: output order equals input order; level_o matches model every cycle.
//  5 Level 3 with overrun_o=1, then clr_i with coincident push 0xEE: level_o=0 and overrun_o=0.
//    rd_valid_o=0; 0xEE is never output.
//  6 Assert rst_i asynchronously between clock edges at level 5: outputs 0 immediately.
//    After release, push 0x3C: it is the first byte popped.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path: data width, default RX FIFO
// geometry and the reset polarity of the active-high domain.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned RX_FIFO_DEPTH   = 8;
  localparam int unsigned RX_FIFO_HIGH_WM = 6;
  localparam logic        RST_ACTIVE      = 1'b1;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: flop-based circular buffer with
// show-ahead head byte, fill level, high-watermark and sticky overrun flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = RX_FIFO_DEPTH,
  parameter int unsigned HIGH_WM = RX_FIFO_HIGH_WM,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [UART_DATA_W-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [AW:0]            level_o,
  output logic                   full_o,
  output logic                   hiwm_o,
  output logic                   overrun_o,
  input  logic                   clr_i
);

`ifndef SYNTHESIS
  if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
    $fatal(1, "uart_rx_fifo: DEPTH=%0d must be a power of 2 in 2..32", DEPTH);
  end
  if (HIGH_WM < 1 || HIGH_WM > DEPTH) begin : g_bad_hiwm
    $fatal(1, "uart_rx_fifo: HIGH_WM=%0d must be in 1..DEPTH", HIGH_WM);
  end
`endif

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_HIWM = (AW + 1)'(HIGH_WM);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            level;
  logic                   overrun;
  logic                   push;
  logic                   pop;

  assign rd_valid_o = (level != '0);
  assign full_o     = (level == LVL_FULL);
  assign hiwm_o     = (level >= LVL_HIWM);
  assign level_o    = level;
  assign overrun_o  = overrun;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop  = rd_valid_o & rd_ready_i;
  assign push = rx_valid_i & (~full_o | pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RST_ACTIVE) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else if (clr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (rx_valid_i && !push) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[wr_ptr] <= rx_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_valid_o) rd_data_o = mem[rd_ptr];
  end

endmodule
